stp16_receiver: RTL and testbench

- Serial-to-parallel receiver for the STP16CPC26-style LED driver link (stp16_clk / stp16_sdi / stp16_le / stp16_noe).
- Oversamples the four link pins on the system clock, shifts in data MSB-first and latches a word on LE.
- Presents each latched word on a valid/ready stream, and reports output-enable state and framing faults.
- Used for loopback verification of the LED driver transmitter and for receiving a chained display stream from another board.

---
 rtl/stp16_receiver.sv | 118 +++++++++++
 tb/tb_stp16_receiver.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stp16_receiver.sv
// Serial-to-parallel receiver for the STP16 LED driver link: oversamples the
// link pins, shifts data MSB-first and hands each latched word to a stream.
module stp16_receiver #(
  parameter int width       = 32,
  parameter int sync_stages = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stp16_clk,
  input  logic             stp16_sdi,
  input  logic             stp16_le,
  input  logic             stp16_noe,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [width-1:0] o_data,
  output logic             o_enable,
  output logic             frame_error,
  output logic             overrun
);

  // Counter must hold width+2 (saturated count plus a coincident shift).
  localparam int cnt_w = $clog2(width + 3);
  localparam logic [cnt_w-1:0] cnt_sat   = cnt_w'(width + 1);
  localparam logic [cnt_w-1:0] cnt_width = cnt_w'(width);

  logic [sync_stages-1:0] clk_sync;
  logic [sync_stages-1:0] sdi_sync;
  logic [sync_stages-1:0] le_sync;
  logic [sync_stages-1:0] noe_sync;

  logic             prev_clk;
  logic             prev_le;
  logic [width-1:0] shift_q;
  logic [cnt_w-1:0] cnt_q;

  logic             sync_clk;
  logic             sync_sdi;
  logic             sync_le;
  logic             sync_noe;
  logic             shift_evt;
  logic             latch_evt;
  logic             accept;
  logic [width-1:0] shift_next;
  logic [width-1:0] candidate;
  logic [cnt_w-1:0] bit_count;

  // sdi runs through the same depth as clk so it stays aligned with the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync <= '0;
      sdi_sync <= '0;
      le_sync  <= '0;
      noe_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[sync_stages-2:0], stp16_clk};
      sdi_sync <= {sdi_sync[sync_stages-2:0], stp16_sdi};
      le_sync  <= {le_sync[sync_stages-2:0], stp16_le};
      noe_sync <= {noe_sync[sync_stages-2:0], stp16_noe};
    end
  end

  assign sync_clk = clk_sync[sync_stages-1];
  assign sync_sdi = sdi_sync[sync_stages-1];
  assign sync_le  = le_sync[sync_stages-1];
  assign sync_noe = noe_sync[sync_stages-1];

  assign shift_evt  = sync_clk & ~prev_clk;
  assign latch_evt  = sync_le & ~prev_le;
  assign shift_next = {shift_q[width-2:0], sync_sdi};

  // The transmitter raises clk and le together on the last bit, so a
  // coincident shift must be folded into the captured word and its count.
  assign candidate = shift_evt ? shift_next : shift_q;
  assign bit_count = cnt_q + cnt_w'(shift_evt);

  // Stream handshake: a word transfers on any cycle with o_valid & o_ready;
  // o_data is frozen while o_valid=1 and o_ready=0, and a new word is taken
  // only when the output slot is empty or being emptied in the same cycle.
  assign accept = ~o_valid | o_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_clk    <= 1'b0;
      prev_le     <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_enable    <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      prev_clk <= sync_clk;
      prev_le  <= sync_le;
      o_enable <= ~sync_noe;
      overrun  <= latch_evt & ~accept;

      if (shift_evt) begin
        shift_q <= shift_next;
      end

      if (latch_evt) begin
        cnt_q <= '0;
      end else if (shift_evt && (cnt_q != cnt_sat)) begin
        cnt_q <= cnt_q + cnt_w'(1);
      end

      if (latch_evt && accept) begin
        o_data      <= candidate;
        o_valid     <= 1'b1;
        frame_error <= (bit_count != cnt_width);
      end else if (o_valid && o_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stp16_receiver.sv
// Bench for stp16_receiver: drives the link pins like the LED driver
// transmitter and compares delivered words against a bit-history model.
module tb_stp16_receiver;

  localparam int W = 32;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         stp16_clk = 1'b0;
  logic         stp16_sdi = 1'b0;
  logic         stp16_le = 1'b0;
  logic         stp16_noe = 1'b1;
  logic         o_ready = 1'b1;
  logic         o_valid;
  logic [W-1:0] o_data;
  logic         o_enable;
  logic         frame_error;
  logic         overrun;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int le_cyc = 0;

  // Monitor state, written only by the monitor process.
  logic [W:0] obs_q[$];
  int         valid_cycles = 0;
  int         overrun_cycles = 0;
  int         first_valid_cyc = -1;
  logic       prev_v = 1'b0;

  // Reference model: every bit shifted since reset plus the count since LE.
  logic [W:0] exp_q[$];
  bit         model_bits[$];
  int         since_latch = 0;
  int         obs_rd = 0;

  stp16_receiver #(.width(W), .sync_stages(S)) dut (
    .clk         (clk),
    .reset       (reset),
    .stp16_clk   (stp16_clk),
    .stp16_sdi   (stp16_sdi),
    .stp16_le    (stp16_le),
    .stp16_noe   (stp16_noe),
    .o_valid     (o_valid),
    .o_ready     (o_ready),
    .o_data      (o_data),
    .o_enable    (o_enable),
    .frame_error (frame_error),
    .overrun     (overrun)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (o_valid) valid_cycles++;
      if (o_valid && !prev_v) first_valid_cyc = cyc;
      if (o_valid && o_ready) obs_q.push_back({frame_error, o_data});
      if (overrun) overrun_cycles++;
    end
    prev_v = o_valid;
  end

  // ---------------- model ----------------
  task automatic model_latch(output logic [W:0] r);
    logic [W-1:0] v;
    int n;
    v = '0;
    n = model_bits.size();
    for (int k = 0; k < W; k++) begin
      if (n - 1 - k >= 0) v[k] = model_bits[n-1-k];
    end
    r = {(since_latch != W), v};
    since_latch = 0;
  endtask

  // ---------------- drivers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_frame(input logic [63:0] word, input int nbits, input bit coincident,
                            input bit do_latch, input bit expect_accept);
    logic [W:0] r;
    for (int i = nbits - 1; i >= 0; i--) begin
      stp16_sdi = word[i];
      step(2);
      stp16_clk = 1'b1;
      model_bits.push_back(word[i]);
      since_latch++;
      if (i == 0 && coincident && do_latch) begin
        stp16_le = 1'b1;
        le_cyc = cyc;
        model_latch(r);
        if (expect_accept) exp_q.push_back(r);
      end
      step(2);
      stp16_clk = 1'b0;
      stp16_le  = 1'b0;
      step(2);
    end
    if (do_latch && !(coincident && nbits > 0)) begin
      stp16_le = 1'b1;
      le_cyc = cyc;
      model_latch(r);
      if (expect_accept) exp_q.push_back(r);
      step(2);
      stp16_le = 1'b0;
      step(2);
    end
  endtask

  task automatic wait_obs(output logic [W:0] r);
    bit found;
    r = 'x;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (obs_q.size() > obs_rd) begin
        r = obs_q[obs_rd];
        obs_rd++;
        found = 1;
      end else begin
        step(1);
      end
    end
  endtask

  task automatic pop_exp(output logic [W:0] e);
    e = 'x;
    if (exp_q.size() > 0) e = exp_q.pop_front();
  endtask

  task automatic sync_queues();
    obs_rd = obs_q.size();
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    step(3);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    checks++; if (o_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", o_data); end
    checks++; if (o_enable !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b want 0", o_enable); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_frame_error: got %b want 0", frame_error); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    reset = 1'b0;
    step(4);
  endtask

  task automatic test_nominal();
    logic [W:0] got, e;
    int base_v;
    sync_queues();
    o_ready = 1'b1;
    base_v = valid_cycles;
    send_frame(64'hA5C3_0F81, 32, 1, 1, 1);
    wait_obs(got);
    pop_exp(e);
    step(3);
    checks++; if (got !== e) begin errors++; $display("FAIL nominal_model: got %h want %h", got, e); end
    checks++; if (got !== {1'b0, 32'hA5C3_0F81}) begin errors++; $display("FAIL nominal_word: got %h want 0a5c30f81", got); end
    checks++; if (first_valid_cyc != le_cyc + 1 + S) begin
      errors++; $display("FAIL nominal_latency: valid at cycle %0d want %0d", first_valid_cyc, le_cyc + 1 + S);
    end
    checks++; if (valid_cycles - base_v != 1) begin
      errors++; $display("FAIL nominal_valid_width: got %0d cycles want 1", valid_cycles - base_v);
    end
  endtask

  task automatic test_coincident();
    logic [W:0] got, e;
    logic [63:0] word;
    sync_queues();
    for (int n = 0; n < 4; n++) begin
      word = {32'h0, $urandom};
      send_frame(word, 32, 1, 1, 1);
      wait_obs(got);
      pop_exp(e);
      checks++; if (got !== e) begin errors++; $display("FAIL coincident_model: got %h want %h", got, e); end
      checks++; if (got[0] !== word[0] || got[W] !== 1'b0) begin
        errors++; $display("FAIL coincident_bit32: got lsb %b err %b want lsb %b err 0", got[0], got[W], word[0]);
      end
    end
  endtask

  task automatic test_short_frame();
    logic [W:0] got, e;
    sync_queues();
    send_frame(64'hFFFF_FFFF, 32, 1, 1, 1);
    wait_obs(got);
    pop_exp(e);
    checks++; if (got !== e) begin errors++; $display("FAIL short_prefix: got %h want %h", got, e); end
    send_frame(64'h00, 8, 0, 1, 1);
    wait_obs(got);
    pop_exp(e);
    checks++; if (got !== {1'b1, 32'hFFFF_FF00}) begin errors++; $display("FAIL short_word: got %h want 1ffffff00", got); end
    checks++; if (got !== e) begin errors++; $display("FAIL short_model: got %h want %h", got, e); end
    send_frame({32'h0, $urandom}, 32, 0, 1, 1);
    wait_obs(got);
    pop_exp(e);
    checks++; if (got !== e || got[W] !== 1'b0) begin errors++; $display("FAIL short_recover: got %h want %h", got, e); end
  endtask

  task automatic test_zero_bit();
    logic [W:0] got, e;
    sync_queues();
    for (int n = 0; n < 2; n++) send_frame(64'h0, 0, 0, 1, 1);
    for (int n = 0; n < 2; n++) begin
      wait_obs(got);
      pop_exp(e);
      checks++; if (got !== e || got[W] !== 1'b1) begin errors++; $display("FAIL zero_bit_frame: got %h want %h", got, e); end
    end
  endtask

  task automatic test_overrun();
    logic [W:0] got, e;
    int base_o;
    sync_queues();
    o_ready = 1'b0;
    base_o = overrun_cycles;
    send_frame(64'h1111_1111, 32, 1, 1, 1);
    step(2);
    pop_exp(e);
    checks++; if (o_valid !== 1'b1 || o_data !== e[W-1:0]) begin
      errors++; $display("FAIL overrun_first: valid %b data %h want 1 %h", o_valid, o_data, e[W-1:0]);
    end
    send_frame(64'h2222_2222, 32, 1, 1, 0);
    step(2);
    checks++; if (overrun_cycles - base_o != 1) begin
      errors++; $display("FAIL overrun_pulse: got %0d cycles want 1", overrun_cycles - base_o);
    end
    checks++; if (o_valid !== 1'b1 || o_data !== 32'h1111_1111 || frame_error !== 1'b0) begin
      errors++; $display("FAIL overrun_hold: valid %b data %h err %b want 1 11111111 0", o_valid, o_data, frame_error);
    end
    o_ready = 1'b1;
    step(1);
    checks++; if (o_valid !== 1'b0 || o_data !== 32'h1111_1111) begin
      errors++; $display("FAIL overrun_release: valid %b data %h want 0 11111111", o_valid, o_data);
    end
    wait_obs(got);
    checks++; if (got !== e) begin errors++; $display("FAIL overrun_delivered: got %h want %h", got, e); end
  endtask

  task automatic test_enable();
    int base_v;
    sync_queues();
    base_v = valid_cycles;
    stp16_noe = 1'b0;
    step(2);
    checks++; if (o_enable !== 1'b0) begin errors++; $display("FAIL enable_early_on: got %b want 0", o_enable); end
    step(1);
    checks++; if (o_enable !== 1'b1) begin errors++; $display("FAIL enable_on: got %b want 1", o_enable); end
    stp16_noe = 1'b1;
    step(2);
    checks++; if (o_enable !== 1'b1) begin errors++; $display("FAIL enable_early_off: got %b want 1", o_enable); end
    step(1);
    checks++; if (o_enable !== 1'b0) begin errors++; $display("FAIL enable_off: got %b want 0", o_enable); end
    checks++; if (valid_cycles != base_v) begin
      errors++; $display("FAIL enable_no_valid: got %0d valid cycles want 0", valid_cycles - base_v);
    end
  endtask

  task automatic test_random();
    logic [W:0] got, e;
    int nb;
    bit co;
    sync_queues();
    for (int n = 0; n < 6; n++) begin
      nb = $urandom_range(30, 34);
      co = 1'($urandom_range(0, 1));
      send_frame({$urandom, $urandom}, nb, co, 1, 1);
      wait_obs(got);
      pop_exp(e);
      checks++; if (got !== e) begin errors++; $display("FAIL random_frame: bits %0d got %h want %h", nb, got, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [W:0] got, e;
    sync_queues();
    stp16_noe = 1'b0;
    step(4);
    send_frame({32'h0, $urandom}, 20, 0, 0, 0);
    reset = 1'b1;
    #1;
    checks++; if (o_valid !== 1'b0 || o_data !== '0 || o_enable !== 1'b0 || frame_error !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL reset_mid_outputs: valid %b data %h en %b err %b ovr %b want all 0",
                         o_valid, o_data, o_enable, frame_error, overrun);
    end
    step(3);
    reset = 1'b0;
    model_bits.delete();
    since_latch = 0;
    step(2);
    sync_queues();
    send_frame(64'hDEAD_BEEF, 32, 1, 1, 1);
    wait_obs(got);
    pop_exp(e);
    checks++; if (got !== {1'b0, 32'hDEAD_BEEF}) begin errors++; $display("FAIL reset_mid_word: got %h want 0deadbeef", got); end
    checks++; if (got !== e) begin errors++; $display("FAIL reset_mid_model: got %h want %h", got, e); end
    checks++; if (o_enable !== 1'b1) begin errors++; $display("FAIL reset_mid_enable: got %b want 1", o_enable); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_nominal();
    test_coincident();
    test_short_frame();
    test_zero_bit();
    test_overrun();
    test_enable();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
